// File: rtl/phase_frame_ctrl_pkg.sv
// Shared constants and FSM encoding for the double-buffered phase frame controller.
package phase_frame_ctrl_pkg;
  localparam int PFC_NUM_CHANNELS = 128;
  localparam int PFC_CLK_CNT_W    = 8;
  localparam int PFC_CLK_CNT_MAX  = 99;
  localparam int PFC_CH_W         = $clog2(PFC_NUM_CHANNELS);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } pfc_state_e;
endpackage

// File: rtl/phase_frame_ctrl_bank.sv
// One shadow/active array pair: writes land in shadow, a copy strobe publishes
// the whole shadow frame into active, which alone drives the outputs.
module phase_bank
  import phase_frame_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS = PFC_NUM_CHANNELS,
  parameter int CLK_CNT_W    = PFC_CLK_CNT_W,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_wr_en,
  input  logic [CH_W-1:0]                   i_wr_channel,
  input  logic [CLK_CNT_W-1:0]              i_wr_phase,
  input  logic                              i_copy,
  output logic [NUM_CHANNELS*CLK_CNT_W-1:0] o_phases,
  output logic [NUM_CHANNELS-1:0]           o_en
);

  logic [CLK_CNT_W-1:0]    r_shadow_phase [NUM_CHANNELS];
  logic [CLK_CNT_W-1:0]    r_active_phase [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_shadow_en;
  logic [NUM_CHANNELS-1:0] r_active_en;

  // Shadow is never cleared by a copy, so later partial writes build on the last frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_shadow_phase[i] <= '0;
        r_active_phase[i] <= '0;
      end
      r_shadow_en <= '0;
      r_active_en <= '0;
    end else begin
      if (i_wr_en) begin
        r_shadow_phase[i_wr_channel] <= i_wr_phase;
        r_shadow_en[i_wr_channel]    <= 1'b1;
      end
      if (i_copy) begin
        r_active_phase <= r_shadow_phase;
        r_active_en    <= r_shadow_en;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign o_phases[g*CLK_CNT_W +: CLK_CNT_W] = r_active_phase[g];
  end
  assign o_en = r_active_en;

endmodule

// File: rtl/phase_frame_ctrl.sv
// Phase frame controller: collects per-channel phase writes in a shadow frame and
// publishes them atomically at the PWM period boundary so outputs never glitch mid-period.
module phase_frame_ctrl
  import phase_frame_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS = PFC_NUM_CHANNELS,
  parameter int CLK_CNT_W    = PFC_CLK_CNT_W,
  parameter int CLK_CNT_MAX  = PFC_CLK_CNT_MAX
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [$clog2(NUM_CHANNELS)-1:0]   wr_channel,
  input  logic [CLK_CNT_W-1:0]              wr_phase,
  input  logic                              commit_req,
  input  logic [CLK_CNT_W-1:0]              cnt,
  output logic [NUM_CHANNELS*CLK_CNT_W-1:0] phases,
  output logic [NUM_CHANNELS-1:0]           pwm_en,
  output logic                              commit_busy,
  output logic                              frame_done,
  output logic                              range_err,
  input  logic                              clear_err
);

  localparam int                   CH_W       = $clog2(NUM_CHANNELS);
  localparam logic [CLK_CNT_W-1:0] LP_CNT_MAX = CLK_CNT_W'(CLK_CNT_MAX);

  pfc_state_e r_state;
  logic       r_wr_ready;
  logic       r_commit_busy;
  logic       r_frame_done;
  logic       r_range_err;

  logic w_wr_acc;
  logic w_in_range;
  logic w_wr_shadow;
  logic w_range_set;
  logic w_swap;

  // A power-of-two channel count leaves no unrepresentable index to reject.
  if (NUM_CHANNELS == (2 ** CH_W)) begin : g_full_range
    assign w_in_range = 1'b1;
  end else begin : g_part_range
    localparam logic [CH_W:0] LP_NUM_CH = (CH_W+1)'(NUM_CHANNELS);
    assign w_in_range = ({1'b0, wr_channel} < LP_NUM_CH);
  end

  assign w_wr_acc    = wr_valid & r_wr_ready;
  assign w_wr_shadow = w_wr_acc & w_in_range;
  assign w_range_set = w_wr_acc & ~w_in_range;
  assign w_swap      = (r_state == ST_PENDING) && (cnt == LP_CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wr_ready    <= 1'b1;
      r_commit_busy <= 1'b0;
      r_frame_done  <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_range_set) begin
        r_range_err <= 1'b1;
      end else if (clear_err) begin
        r_range_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (commit_req) begin
            r_state       <= ST_PENDING;
            r_wr_ready    <= 1'b0;
            r_commit_busy <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (w_swap) begin
            r_state       <= ST_IDLE;
            r_wr_ready    <= 1'b1;
            r_commit_busy <= 1'b0;
            r_frame_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  phase_bank #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CLK_CNT_W    (CLK_CNT_W),
    .CH_W         (CH_W)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_wr_shadow),
    .i_wr_channel (wr_channel),
    .i_wr_phase   (wr_phase),
    .i_copy       (w_swap),
    .o_phases     (phases),
    .o_en         (pwm_en)
  );

  assign wr_ready    = r_wr_ready;
  assign commit_busy = r_commit_busy;
  assign frame_done  = r_frame_done;
  assign range_err   = r_range_err;

endmodule

// File: tb/tb_phase_frame_ctrl.sv
// Scoreboard bench for phase_frame_ctrl; a 100-channel build leaves indices 100..127 out of range.
module tb_phase_frame_ctrl;
  localparam int NCH  = 100;
  localparam int W    = 8;
  localparam int MAX  = 99;
  localparam int CH_W = $clog2(NCH);
  localparam int PW   = NCH * W;

  typedef logic [1023:0] wide_t;
  typedef struct {
    int             due;
    logic [PW-1:0]  ph;
    logic [NCH-1:0] en;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic            commit_req = 1'b0;
  logic            clear_err = 1'b0;
  logic [CH_W-1:0] wr_channel = '0;
  logic [W-1:0]    wr_phase = '0;
  logic [W-1:0]    cnt = '0;
  logic            wr_ready;
  logic [PW-1:0]   phases;
  logic [NCH-1:0]  pwm_en;
  logic            commit_busy;
  logic            frame_done;
  logic            range_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0]   m_ph [NCH];
  logic [NCH-1:0] m_en;
  exp_t           exp_q[$];

  phase_frame_ctrl #(
    .NUM_CHANNELS (NCH),
    .CLK_CNT_W    (W),
    .CLK_CNT_MAX  (MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_channel  (wr_channel),
    .wr_phase    (wr_phase),
    .commit_req  (commit_req),
    .cnt         (cnt),
    .phases      (phases),
    .pwm_en      (pwm_en),
    .commit_busy (commit_busy),
    .frame_done  (frame_done),
    .range_err   (range_err),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input wide_t act, input wide_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cnt = (cnt == W'(MAX)) ? '0 : cnt + 8'd1;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i <= MAX + 1; i++) begin
      if (int'(cnt) == v) break;
      step();
    end
  endtask

  function automatic logic [PW-1:0] model_ph();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = m_ph[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) m_ph[i] = '0;
    m_en = '0;
  endtask

  task automatic push_commit();
    exp_t e;
    e.due = cyc + ((int'(cnt) == MAX) ? MAX + 2 : MAX - int'(cnt) + 1);
    e.ph  = model_ph();
    e.en  = m_en;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " phases"}, wide_t'(phases), wide_t'(0));
    check({tag, " pwm_en"}, wide_t'(pwm_en), wide_t'(0));
    check({tag, " wr_ready"}, wide_t'(wr_ready), wide_t'(1'b1));
    check({tag, " busy"}, wide_t'(commit_busy), wide_t'(1'b0));
    check({tag, " frame_done"}, wide_t'(frame_done), wide_t'(1'b0));
    check({tag, " range_err"}, wide_t'(range_err), wide_t'(1'b0));
  endtask

  task automatic commit();
    commit_req = 1'b1;
    push_commit();
    step();
    commit_req = 1'b0;
    check("commit busy", wide_t'(commit_busy), wide_t'(1'b1));
    check("commit ready_low", wide_t'(wr_ready), wide_t'(1'b0));
  endtask

  task automatic wr(input int ch, input logic [W-1:0] ph, input logic clr, input logic with_commit);
    wr_channel = CH_W'(ch);
    wr_phase   = ph;
    wr_valid   = 1'b1;
    clear_err  = clr;
    commit_req = with_commit;
    check("wr ready", wide_t'(wr_ready), wide_t'(1'b1));
    if (ch < NCH) begin
      m_ph[ch] = ph;
      m_en[ch] = 1'b1;
    end
    if (with_commit) push_commit();
    step();
    wr_valid   = 1'b0;
    clear_err  = 1'b0;
    commit_req = 1'b0;
    if (with_commit) check("wr+commit busy", wide_t'(commit_busy), wide_t'(1'b1));
  endtask

  task automatic wait_frame(input string tag);
    exp_t           e;
    logic [PW-1:0]  p0;
    logic [NCH-1:0] e0;
    bit             seen;
    bit             moved;
    p0 = phases;
    e0 = pwm_en;
    seen = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 3 * (MAX + 1); i++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      if (phases !== p0 || pwm_en !== e0) moved = 1'b1;
    end
    check({tag, " stable"}, wide_t'(moved), wide_t'(1'b0));
    check({tag, " seen"}, wide_t'(seen), wide_t'(1'b1));
    check({tag, " queue"}, wide_t'(exp_q.size()), wide_t'(1));
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " latency"}, wide_t'(cyc), wide_t'(e.due));
      check({tag, " cnt_at_vis"}, wide_t'(cnt), wide_t'(0));
      check({tag, " phases"}, wide_t'(phases), wide_t'(e.ph));
      check({tag, " pwm_en"}, wide_t'(pwm_en), wide_t'(e.en));
    end
  endtask

  task automatic pulse_end(input string tag);
    step();
    check({tag, " pulse"}, wide_t'(frame_done), wide_t'(1'b0));
  endtask

  initial begin
    bit bad;
    model_clear();
    repeat (3) step();
    rst = 1'b0;
    check_reset("reset");

    // single write then commit mid-period
    wr(5, 8'h20, 1'b0, 1'b0);
    wait_cnt(10);
    commit();
    wait_frame("t1");
    pulse_end("t1");

    // commit on the terminal count waits a full period
    wait_cnt(MAX);
    commit();
    wait_frame("t2");
    pulse_end("t2");

    // write held off while pending, published by a second commit
    wait_cnt(20);
    commit();
    wr_channel = CH_W'(7);
    wr_phase   = 8'h55;
    wr_valid   = 1'b1;
    check("t3 ready_pending", wide_t'(wr_ready), wide_t'(1'b0));
    wait_frame("t3a");
    check("t3 ready_after", wide_t'(wr_ready), wide_t'(1'b1));
    m_ph[7] = 8'h55;
    m_en[7] = 1'b1;
    step();
    wr_valid = 1'b0;
    check("t3a pulse", wide_t'(frame_done), wide_t'(1'b0));
    commit();
    wait_frame("t3b");
    pulse_end("t3b");

    // out-of-range writes and the sticky error flag
    wr(120, 8'hAA, 1'b0, 1'b0);
    check("t4 err_set", wide_t'(range_err), wide_t'(1'b1));
    repeat (3) step();
    check("t4 err_sticky", wide_t'(range_err), wide_t'(1'b1));
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t4 err_clear", wide_t'(range_err), wide_t'(1'b0));
    wr(127, 8'hBB, 1'b1, 1'b0);
    check("t4 set_wins", wide_t'(range_err), wide_t'(1'b1));
    commit();
    wait_frame("t4");
    pulse_end("t4");

    // accumulation across commits, including a write in the commit cycle
    wait_cnt(30);
    wr(0, 8'h10, 1'b0, 1'b1);
    wait_frame("t5a");
    pulse_end("t5a");
    wr(1, 8'h30, 1'b0, 1'b0);
    commit();
    wait_frame("t5b");
    pulse_end("t5b");
    check("t5 ch0", wide_t'(phases[0 +: W]), wide_t'(8'h10));
    check("t5 ch1", wide_t'(phases[W +: W]), wide_t'(8'h30));

    // reset aborts a pending commit
    wait_cnt(40);
    commit();
    wait_cnt(50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    check_reset("t6 rst");
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (frame_done || commit_busy || phases != '0 || pwm_en != '0) bad = 1'b1;
    end
    check("t6 no_swap", wide_t'(bad), wide_t'(1'b0));
    check_reset("t6 end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
